p_divider: RTL
==============

# p_divider

Multi-cycle 32-bit integer divider functional unit for the PE, placed beside the partitioned shifter in the FU datapath. The shifter only bit-reverses and aligns operands for DIV/DIVU; this block consumes the same `a_i`/`b_i`/`instr_i` operand bundle and produces quotient and remainder. It uses an iterative radix-2 restoring algorithm with a valid/ready handshake on both sides.

## Interface
- Parameters: none. Width is `N_BITS` from `pea_pkg` and must equal 32. Elaboration fails otherwise.
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `clear_i`  in  1  synchronous abort. Returns the block to IDLE.
- `a_i`  in  N_BITS  dividend.
- `b_i`  in  N_BITS  divisor.
- `instr_i`  in  fu_instr_t  operation. Only `DIV` (signed) and `DIVU` (unsigned) are acted on.
- `in_valid_i`  in  1  operand valid.
- `in_ready_o`  out  1  block can accept an operation.
- `res_o`  out  N_BITS  quotient.
- `rem_o`  out  N_BITS  remainder.
- `valid_o`  out  1  result valid.
- `out_ready_i`  in  1  consumer accepts the result.

## Operation
- States are IDLE, ITER and DONE.
- Reset values: state is IDLE, `valid_o`=0, `res_o`=0, `rem_o`=0, internal registers are 0. `in_ready_o`=1, decoded combinationally from IDLE.
- **Accept.** An operation is accepted when `in_valid_i & in_ready_o` and `instr_i` is `DIV` or `DIVU`. Any other `instr_i` is ignored: no state change.
- **Capture on accept.** The block registers:
  - the operation type;
  - the dividend sign and divisor sign (both forced to 0 for DIVU);
  - |a| into Q, |b| into D, 0 into R (33 bits);
  - the iteration counter, loaded with N=32.
- **Special cases on accept.** These go straight to DONE and skip ITER:
  - Divisor = 0: q = 0xFFFFFFFF, r = a.
  - DIV with a=0x80000000 and b=0xFFFFFFFF: q = 0x80000000, r = 0.
- **ITER, one bit per cycle:**
  - t = {R[31:0], Q[31]}.
  - If t ≥ {1'b0, D}: R = t − D and the quotient bit is 1. Otherwise R = t and the quotient bit is 0.
  - Q = {Q[30:0], qbit}.
  - The counter decrements. When the counter reaches 1, the state moves to DONE.
- **Sign fix,** combinational from the registered signs:
  - For DIV, `res_o` is −Q if the signs differ.
  - `rem_o` is −R[31:0] if the dividend was negative.
  - For DIVU, results are unmodified.
- **DONE.** `valid_o`=1. `res_o`/`rem_o` are held stable until `out_ready_i`=1, then the state returns to IDLE.
- `in_ready_o`=0 in ITER and DONE. There is no result/accept overlap.
- **`clear_i`:**
  - Has priority over every other event, including a simultaneous accept or output handshake.
  - Next state is IDLE and `valid_o` drops the following cycle.
  - Any captured operation is discarded.
- **`rst_i` mid-operation:** asynchronous return to the reset values listed above. No result is produced.

## Timing
- Cycle 0 is the accept cycle; the accept edge ends it.
- Normal operation: ITER occupies cycles 1..32 and `valid_o`=1 from cycle 33.
- Special cases: `valid_o`=1 in cycle 1.
- Results are registered. Sign fix is the only combinational logic on `res_o`/`rem_o`.
- Output handshake on cycle k → IDLE in cycle k+1. The earliest next accept is cycle k+1.
- Throughput (normal operation): one operation per 34 cycles, assuming `out_ready_i` is tied high.

## Configuration
- Macro: `P_DIV_EARLY_TERM_EN`.
- **Defined:**
  - On accept, a leading-zero count c = clz(|a|) is computed.
  - Q is loaded with |a| << c and N = 32 − c.
  - `valid_o` asserts in cycle N+1.
  - If |a| = 0 (and the divisor is non-zero), the block goes directly to DONE with q=0, r=0, and `valid_o` asserts in cycle 1.
- **Undefined:** N = 32 always. No clz logic is synthesized.
- Results are bit-identical in both builds.

## Structure
- `pea_pkg` holds:
  - `N_BITS` and `fu_instr_t` (`DIV`, `DIVU`, already present);
  - a new `div_state_t` enum {IDLE, ITER, DONE};
  - a new constant `DIV_ITERS` = 32.
- One sub-module, `p_clz32`: a 32-bit combinational leading-zero counter with a 6-bit output (32 for an all-zero input). It is instantiated only under `P_DIV_EARLY_TERM_EN`.

## Test plan
- **Unsigned divide:** DIVU a=100, b=7 → `res_o`=14, `rem_o`=2. `valid_o` rises in cycle 33 (cycle 8 with the macro, clz=25).
- **Signed divide:** DIV a=0xFFFFFFF9 (−7), b=2 → `res_o`=0xFFFFFFFD, `rem_o`=0xFFFFFFFF.
  - Also DIV a=7, b=0xFFFFFFFE → `res_o`=0xFFFFFFFD, `rem_o`=1.
- **Divide by zero and overflow:**
  - DIVU a=5, b=0 → `res_o`=0xFFFFFFFF, `rem_o`=5, `valid_o` in cycle 1.
  - DIV a=0x80000000, b=0xFFFFFFFF → `res_o`=0x80000000, `rem_o`=0, `valid_o` in cycle 1.
- **Backpressure:** hold `out_ready_i`=0 for 10 cycles after `valid_o` rises → outputs stable and `in_ready_o`=0 throughout.
  - Then a second `in_valid_i` presented during DONE is not accepted until the cycle after the output handshake.
- **Abort:** assert `clear_i` in cycle 10 of DIVU 0xFFFFFFFF/3 → IDLE in cycle 11 and `valid_o` never asserts.
  - A new DIVU 9/3 then returns q=3, r=0.
  - Repeat with `rst_i` pulsed mid-ITER → all outputs return to their reset values immediately.
- **Non-divide instruction:** `instr_i`=LSH with `in_valid_i`=1 → no accept, state stays IDLE, `valid_o` stays 0.

Source files
------------

// File: rtl/pea_pkg.sv
// Shared PE datapath types and constants: operand width, FU opcodes and divider FSM states.
package pea_pkg;

    localparam int unsigned N_BITS = 32;

    typedef enum logic [3:0] {
        NOP,
        ADD,
        SUB,
        MUL,
        LSH,
        RSH,
        ASH,
        DIV,
        DIVU
    } fu_instr_t;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } div_state_t;

    localparam int unsigned DIV_ITERS = 32;

endpackage

// File: rtl/p_clz32.sv
// 32-bit combinational leading-zero counter; an all-zero input yields 32.
module p_clz32 (
    input  logic [31:0] a_i,
    output logic [5:0]  cnt_o
);

    logic found;

    always_comb begin
        found = 1'b0;
        cnt_o = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (!found) begin
                if (a_i[31 - i]) begin
                    found = 1'b1;
                end else begin
                    cnt_o = cnt_o + 6'd1;
                end
            end
        end
    end

endmodule

// File: rtl/p_divider.sv
// Iterative radix-2 restoring divider (DIV/DIVU) with valid/ready handshakes on both sides.
// Build option P_DIV_EARLY_TERM_EN skips the dividend's leading zeros to shorten ITER.
module p_divider
    import pea_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic [N_BITS-1:0] a_i,
    input  logic [N_BITS-1:0] b_i,
    input  fu_instr_t         instr_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [N_BITS-1:0] res_o,
    output logic [N_BITS-1:0] rem_o,
    output logic              valid_o,
    input  logic              out_ready_i
);

    generate
        if (N_BITS != 32) begin : g_width_check
            $error("p_divider requires N_BITS == 32");
        end
    endgenerate

    div_state_t  state_q, state_d;
    logic        is_div_q, is_div_d;
    logic        a_neg_q, a_neg_d;
    logic        b_neg_q, b_neg_d;
    logic [31:0] q_q, q_d;
    logic [31:0] d_q, d_d;
    logic [32:0] r_q, r_d;
    logic [5:0]  cnt_q, cnt_d;

    logic        accept;
    logic        is_div_op;
    logic        a_neg_in, b_neg_in;
    logic [31:0] a_abs, b_abs;
    logic        div_zero, div_ovf, special;
    logic [31:0] q_load;
    logic [5:0]  n_load;
    logic [32:0] t_val, t_diff;
    logic        t_ge;
    logic        r_msb_unused;

    // Remainder never exceeds the divisor, so R[32] is not needed downstream.
    assign r_msb_unused = r_q[32];

    always_comb begin
        is_div_op = (instr_i == DIV);
        accept    = in_valid_i && (state_q == IDLE) && ((instr_i == DIV) || (instr_i == DIVU));
        a_neg_in  = is_div_op & a_i[31];
        b_neg_in  = is_div_op & b_i[31];
        a_abs     = a_neg_in ? -a_i : a_i;
        b_abs     = b_neg_in ? -b_i : b_i;
        div_zero  = (b_i == '0);
        div_ovf   = is_div_op && (a_i == 32'h8000_0000) && (b_i == '1);
        special   = div_zero | div_ovf;
`ifdef P_DIV_EARLY_TERM_EN
        special   = special | (a_abs == '0);
`endif
    end

`ifdef P_DIV_EARLY_TERM_EN
    logic [5:0] lz;

    p_clz32 u_clz (
        .a_i   (a_abs),
        .cnt_o (lz)
    );

    // Leading zeros of |a| would only shift zero quotient bits in, so start past them.
    always_comb begin
        q_load = a_abs << lz;
        n_load = 6'd32 - lz;
    end
`else
    always_comb begin
        q_load = a_abs;
        n_load = 6'(DIV_ITERS);
    end
`endif

    always_comb begin
        t_val  = {r_q[31:0], q_q[31]};
        t_ge   = (t_val >= {1'b0, d_q});
        t_diff = t_val - {1'b0, d_q};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = special ? DONE : ITER;
            ITER: if (cnt_q == 6'd1) state_d = DONE;
            DONE: if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear_i) state_d = IDLE;
    end

    always_comb begin
        in_ready_o = (state_q == IDLE);
        valid_o    = (state_q == DONE);
        res_o      = (is_div_q && (a_neg_q ^ b_neg_q)) ? -q_q : q_q;
        rem_o      = a_neg_q ? -r_q[31:0] : r_q[31:0];
    end

    always_comb begin
        is_div_d = is_div_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        q_d      = q_q;
        d_d      = d_q;
        r_d      = r_q;
        cnt_d    = cnt_q;
        if (clear_i) begin
            is_div_d = 1'b0;
            a_neg_d  = 1'b0;
            b_neg_d  = 1'b0;
            q_d      = '0;
            d_d      = '0;
            r_d      = '0;
            cnt_d    = '0;
        end else if (accept) begin
            is_div_d = is_div_op;
            a_neg_d  = a_neg_in;
            b_neg_d  = b_neg_in;
            q_d      = q_load;
            d_d      = b_abs;
            r_d      = '0;
            cnt_d    = n_load;
            // Special results are loaded already sign-corrected, so the sign fix is disabled.
            if (div_zero) begin
                q_d     = '1;
                r_d     = {1'b0, a_i};
                a_neg_d = 1'b0;
                b_neg_d = 1'b0;
            end else if (div_ovf) begin
                q_d     = 32'h8000_0000;
                a_neg_d = 1'b0;
                b_neg_d = 1'b0;
            end
`ifdef P_DIV_EARLY_TERM_EN
            else if (a_abs == '0) begin
                q_d     = '0;
                a_neg_d = 1'b0;
                b_neg_d = 1'b0;
            end
`endif
        end else if (state_q == ITER) begin
            r_d   = t_ge ? t_diff : t_val;
            q_d   = {q_q[30:0], t_ge};
            cnt_d = cnt_q - 6'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            is_div_q <= 1'b0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            q_q      <= '0;
            d_q      <= '0;
            r_q      <= '0;
            cnt_q    <= '0;
        end else begin
            is_div_q <= is_div_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            q_q      <= q_d;
            d_q      <= d_d;
            r_q      <= r_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
